sha256_digest_serializer: RTL and testbench

//  Output-side partner of the SHA-256 core's valid/yumi result interface.
//  - Receives a full digest from the core and acknowledges it with yumi.
//  - Streams the digest out to the narrow FSB-side link as word_width_p-bit words,

---
 rtl/sha256_digest_serializer.sv | 99 +++++++++
 tb/tb_sha256_digest_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_digest_serializer.sv
// Buffers one SHA-256 digest taken from the core over valid/yumi and streams it
// out as word_width_p-bit words over a valid/ready link, with no bubble between digests.
module sha256_digest_serializer #(
    parameter int digest_width_p = 256,
    parameter int word_width_p   = 32,
    parameter bit msb_first_p    = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic                      digest_v_i,
    input  logic [digest_width_p-1:0] digest_i,
    output logic                      digest_yumi_o,
    output logic                      v_o,
    output logic [word_width_p-1:0]   data_o,
    output logic                      last_o,
    input  logic                      ready_i
);

    localparam int words_lp       = digest_width_p / word_width_p;
    localparam int index_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam logic [index_width_lp-1:0] last_index_lp = index_width_lp'(words_lp - 1);

    typedef enum logic {
        e_idle = 1'b0,
        e_send = 1'b1
    } state_t;

    state_t                      state_r;
    logic [index_width_lp-1:0]   index_r;
    logic [digest_width_p-1:0]   buf_r;
    logic                        v_r;
    logic [word_width_p-1:0]     data_r;
    logic                        last_r;

    logic                        at_last_s;
    logic                        yumi_s;
    logic [index_width_lp-1:0]   next_index_s;

    function automatic logic [word_width_p-1:0] word_sel(
        input logic [digest_width_p-1:0] digest,
        input int                        k
    );
        int pos;
        pos = msb_first_p ? (words_lp - 1 - k) : k;
        return digest[pos*word_width_p +: word_width_p];
    endfunction

    // Acceptance: in idle whenever enabled, otherwise only on the final handshake.
    always_comb begin
        at_last_s    = (index_r == last_index_lp);
        next_index_s = index_r + index_width_lp'(1);
        yumi_s       = 1'b0;
        if (reset_n_i && en_i && digest_v_i) begin
            case (state_r)
                e_idle:  yumi_s = 1'b1;
                e_send:  yumi_s = ready_i & at_last_s;
                default: yumi_s = 1'b0;
            endcase
        end else begin
            yumi_s = 1'b0;
        end
    end

    // Capture/stream state machine; data_o is re-registered from the buffer on each advance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            index_r <= '0;
            buf_r   <= '0;
            v_r     <= 1'b0;
            data_r  <= '0;
            last_r  <= 1'b0;
        end else if (yumi_s) begin
            state_r <= e_send;
            index_r <= '0;
            buf_r   <= digest_i;
            v_r     <= 1'b1;
            data_r  <= word_sel(digest_i, 0);
            last_r  <= (words_lp == 1);
        end else if ((state_r == e_send) && ready_i) begin
            if (at_last_s) begin
                state_r <= e_idle;
                v_r     <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                index_r <= next_index_s;
                data_r  <= word_sel(buf_r, int'(next_index_s));
                last_r  <= (next_index_s == last_index_lp);
            end
        end
    end

    assign digest_yumi_o = yumi_s;
    assign v_o           = v_r;
    assign data_o        = data_r;
    assign last_o        = last_r;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed bench for sha256_digest_serializer: a queue-based reference model checked every
// cycle, plus literal expectations for each scenario, on both word orders.
module tb_sha256_digest_serializer;

    localparam int W = 32;
    localparam int N = 8;
    localparam int D = 256;

    logic         clk = 1'b0;
    logic         rst_n, en, dv, ready;
    logic [D-1:0] digest;
    logic         yumi, v, last;
    logic [W-1:0] data;
    logic         yumi_m, v_m, last_m;
    logic [W-1:0] data_m;

    int tests_run = 0;
    int failed    = 0;

    logic [W-1:0] q_l[$];
    logic [W-1:0] q_m[$];
    logic         model_yumi;

    sha256_digest_serializer #(.digest_width_p(D), .word_width_p(W), .msb_first_p(1'b0)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .digest_v_i(dv), .digest_i(digest),
        .digest_yumi_o(yumi), .v_o(v), .data_o(data), .last_o(last), .ready_i(ready)
    );

    sha256_digest_serializer #(.digest_width_p(D), .word_width_p(W), .msb_first_p(1'b1)) dut_m (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .digest_v_i(dv), .digest_i(digest),
        .digest_yumi_o(yumi_m), .v_o(v_m), .data_o(data_m), .last_o(last_m), .ready_i(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [D-1:0] make_digest(input logic [W-1:0] base);
        logic [D-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = base + W'(k);
        return d;
    endfunction

    // A digest is taken when nothing is queued, or when the only queued word leaves now.
    function automatic logic exp_yumi();
        return rst_n && en && dv && ((q_l.size() == 0) || ((q_l.size() == 1) && ready));
    endfunction

    // Reference model: a queue of the words still owed downstream, for each word order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_l.delete();
            q_m.delete();
        end else begin
            model_yumi = exp_yumi();
            if ((q_l.size() > 0) && ready) begin
                void'(q_l.pop_front());
                void'(q_m.pop_front());
            end
            if (model_yumi) begin
                for (int k = 0; k < N; k++) begin
                    q_l.push_back(digest[k*W +: W]);
                    q_m.push_back(digest[(N-1-k)*W +: W]);
                end
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        chk("model_yumi", W'(yumi), W'(exp_yumi()));
        chk("model_yumi_m", W'(yumi_m), W'(exp_yumi()));
        chk("model_v", W'(v), W'(q_l.size() != 0));
        chk("model_v_m", W'(v_m), W'(q_m.size() != 0));
        if (q_l.size() != 0) begin
            chk("model_data", data, q_l[0]);
            chk("model_last", W'(last), W'(q_l.size() == 1));
            chk("model_data_m", data_m, q_m[0]);
            chk("model_last_m", W'(last_m), W'(q_m.size() == 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a digest with ready high, expect it taken this cycle, then drop valid.
    task automatic load(input string name, input logic [W-1:0] base);
        digest = make_digest(base);
        dv     = 1'b1;
        en     = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        chk(name, W'(yumi), W'(1));
        step();
        dv = 1'b0;
    endtask

    logic [W-1:0] seen[$];
    logic [W-1:0] prev;

    initial begin
        rst_n  = 1'b1;
        en     = 1'b0;
        dv     = 1'b0;
        ready  = 1'b0;
        digest = '0;
        #2;
        rst_n  = 1'b0;

        // 1: reset, with a digest offered that must not be taken
        en     = 1'b1;
        dv     = 1'b1;
        digest = make_digest(32'hA000_0000);
        repeat (3) begin
            @(negedge clk);
            chk("rst_yumi_held", W'(yumi), W'(0));
            step();
        end
        dv    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_v", W'(v), W'(0));
        chk("rst_yumi", W'(yumi), W'(0));
        chk("rst_data", data, 32'h0000_0000);
        chk("rst_last", W'(last), W'(0));
        step();

        // 2 and 6b: single digest, both word orders
        load("t2_yumi", 32'hA000_0000);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("t2_v", W'(v), W'(1));
            chk("t2_data", data, 32'hA000_0000 + W'(k));
            chk("t2_last", W'(last), W'(k == N-1));
            chk("t6_msb_data", data_m, 32'hA000_0007 - W'(k));
            chk("t6_msb_last", W'(last_m), W'(k == N-1));
            step();
        end
        @(negedge clk);
        chk("t2_v_end", W'(v), W'(0));
        step();

        // 3: backpressure, ready alternating 1,0 from T+1
        load("t3_yumi", 32'hA000_0000);
        seen.delete();
        for (int c = 1; c <= 15; c++) begin
            ready = (c % 2 == 1);
            @(negedge clk);
            if ((c % 2 == 1) && (c > 1)) chk("t3_hold", data, prev);
            if (ready && v) seen.push_back(data);
            prev = data;
            step();
        end
        @(negedge clk);
        chk("t3_v_end", W'(v), W'(0));
        chk("t3_count", W'(seen.size()), W'(N));
        for (int k = 0; k < seen.size(); k++) chk("t3_order", seen[k], 32'hA000_0000 + W'(k));
        ready = 1'b1;
        step();

        // 4: back-to-back digests, second offered during the final word
        load("t4_yumi_a", 32'hA000_0000);
        for (int k = 0; k < N; k++) begin
            if (k == N-1) begin
                digest = make_digest(32'hB000_0000);
                dv     = 1'b1;
            end
            @(negedge clk);
            chk("t4_data_a", data, 32'hA000_0000 + W'(k));
            if (k == N-1) chk("t4_yumi_b", W'(yumi), W'(1));
            step();
        end
        dv = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("t4_v_b", W'(v), W'(1));
            chk("t4_data_b", data, 32'hB000_0000 + W'(k));
            step();
        end
        @(negedge clk);
        chk("t4_v_end", W'(v), W'(0));
        step();

        // 5: enable gating
        en     = 1'b0;
        dv     = 1'b1;
        ready  = 1'b1;
        digest = make_digest(32'hC000_0000);
        repeat (5) begin
            @(negedge clk);
            chk("t5_no_yumi", W'(yumi), W'(0));
            chk("t5_no_v", W'(v), W'(0));
            step();
        end
        en = 1'b1;
        @(negedge clk);
        chk("t5_yumi", W'(yumi), W'(1));
        step();
        dv = 1'b0;
        @(negedge clk);
        chk("t5_v", W'(v), W'(1));
        chk("t5_data", data, 32'hC000_0000);
        repeat (8) step();
        @(negedge clk);
        chk("t5_v_end", W'(v), W'(0));
        step();

        // 6a: reset pulse after word 3 has been handed over
        load("t6_yumi", 32'hA000_0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_data", data, 32'hA000_0000 + W'(k));
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("t6_v_drop", W'(v), W'(0));
        chk("t6_v_drop_m", W'(v_m), W'(0));
        step();
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t6_no_flush", W'(v), W'(0));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
